// File: rtl/sccb_cfg_master_pkg.sv
// sccb_cfg_master_pkg: shared state encoding and table/frame constants for the SCCB configuration master.
package sccb_cfg_master_pkg;
    typedef enum logic [3:0] {
        S_PWDN, S_BOOT, S_FETCH, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;
    localparam logic [15:0] TBL_END        = 16'hFFFF;
    localparam logic [7:0]  TBL_DELAY_ADDR = 8'hF0;
    localparam int          PHASE_BITS     = 9;
    localparam int          FRAME_BITS     = 3 * PHASE_BITS;
endpackage

// File: rtl/sccb_cfg_master_if.sv
// sccb_cfg_master_if: control handshake and camera-side pins of the SCCB configuration master.
interface sccb_cfg_master_if #(parameter int IW = 7);
    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] cfg_idx;
    logic          CMOS_SIO_C;
    logic          CMOS_SIO_D;
    logic          CMOS_RESET;
    logic          CMOS_PWDN;
    modport master (input start, output busy, done, cfg_idx, CMOS_SIO_C, CMOS_SIO_D, CMOS_RESET, CMOS_PWDN);
    modport slave  (output start, input busy, done, cfg_idx, CMOS_SIO_C, CMOS_SIO_D, CMOS_RESET, CMOS_PWDN);
endinterface

// File: rtl/sccb_cfg_rom.sv
// sccb_cfg_rom: combinational {addr,data} register table; TABLE 0 is the RGB565/VGA camera list.
module sccb_cfg_rom import sccb_cfg_master_pkg::*; #(
    parameter int IW    = 7,
    parameter int TABLE = 0
) (
    input  logic [IW-1:0] idx_i,
    output logic [15:0]   entry_o
);
    logic [7:0] i;
    assign i = 8'(idx_i);
    always_comb begin
        entry_o = TBL_END;
        if (TABLE == 1)
            entry_o = i == 8'd0 ? 16'hF003 : i == 8'd1 ? 16'h1280 : i == 8'd2 ? 16'h1101 : TBL_END;
        else if (TABLE == 2)
            entry_o = i == 8'd0 ? 16'h0123 : i == 8'd1 ? 16'h4567 : i == 8'd2 ? 16'h89AB : 16'hCDEF;
        else
            case (i)
                8'd0:    entry_o = 16'h1280;
                8'd1:    entry_o = 16'hF00A;
                8'd2:    entry_o = 16'h1101;
                8'd3:    entry_o = 16'h1204;
                8'd4:    entry_o = 16'h40D0;
                8'd5:    entry_o = 16'h8C00;
                8'd6:    entry_o = 16'h3A04;
                8'd7:    entry_o = 16'h3DC0;
                8'd8:    entry_o = 16'h1713;
                8'd9:    entry_o = 16'h1801;
                8'd10:   entry_o = 16'h32B6;
                8'd11:   entry_o = 16'h1902;
                8'd12:   entry_o = 16'h1A7A;
                8'd13:   entry_o = 16'h030A;
                8'd14:   entry_o = 16'h0C00;
                8'd15:   entry_o = 16'h3E00;
                8'd16:   entry_o = 16'h703A;
                8'd17:   entry_o = 16'h7135;
                8'd18:   entry_o = 16'h7211;
                8'd19:   entry_o = 16'h73F0;
                8'd20:   entry_o = 16'hA202;
                8'd21:   entry_o = 16'h13E7;
                default: entry_o = TBL_END;
            endcase
    end
endmodule

// File: rtl/sccb_cfg_master.sv
// sccb_cfg_master: camera power-up sequencer and table-driven SCCB write master.
// Bus outputs are decoded from next-state values so every pin is registered yet aligned with its state.
module sccb_cfg_master import sccb_cfg_master_pkg::*; #(
    parameter int          CLK_HZ      = 50000000,
    parameter int          SCCB_HZ     = 100000,
    parameter logic [7:0]  DEV_ID      = 8'h42,
    parameter int          PWDN_CYCLES = 500000,
    parameter int          BOOT_CYCLES = 1500000,
    parameter int          MS_CYCLES   = 50000,
    parameter int          TBL_DEPTH   = 128,
    parameter int          TABLE       = 0
) (
    input logic               CLK_IN,
    input logic               nRST,
    sccb_cfg_master_if.master bus
);
    localparam int QRAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int QTR  = QRAW < 1 ? 1 : QRAW;
    localparam int IW   = $clog2(TBL_DEPTH);
    state_t                state_q, state_d, adv_state;
    logic [31:0]           cnt_q, cnt_d, dly;
    logic [1:0]            qtr_q, qtr_d;
    logic [4:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [IW-1:0]         idx_q, idx_d, adv_idx;
    logic [15:0]           entry;
    logic                  qend, last, sioc_d, siod_d;
    logic                  sioc_q, siod_q, pwdn_q, rst_q, busy_q, done_q;
    sccb_cfg_rom #(.IW(IW), .TABLE(TABLE)) u_rom (.idx_i(idx_q), .entry_o(entry));
    assign qend      = cnt_q == 32'(QTR - 1);
    assign last      = idx_q == IW'(TBL_DEPTH - 1);
    assign dly       = 32'(entry[7:0]) * 32'(MS_CYCLES);
    // the final table slot finishes the run instead of wrapping to index 0
    assign adv_state = last ? S_DONE : S_FETCH;
    assign adv_idx   = last ? idx_q : idx_q + 1'b1;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        case (state_q)
            S_PWDN: if (cnt_q == 32'(PWDN_CYCLES - 1)) begin state_d = S_BOOT; cnt_d = '0; end
            S_BOOT: if (cnt_q == 32'(BOOT_CYCLES - 1)) begin state_d = S_FETCH; cnt_d = '0; end
            S_FETCH: begin
                cnt_d = '0;
                qtr_d = '0;
                bit_d = '0;
                if (entry == TBL_END) state_d = S_DONE;
                else if (entry[15:8] == TBL_DELAY_ADDR && entry[7:0] != 8'd0) state_d = S_DELAY;
                else if (entry[15:8] == TBL_DELAY_ADDR) begin state_d = adv_state; idx_d = adv_idx; end
                else begin
                    state_d = S_START;
                    sh_d    = {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
                end
            end
            S_DELAY: if (cnt_q == dly - 32'd1) begin state_d = adv_state; idx_d = adv_idx; end
            S_START, S_BITS, S_STOP, S_GAP: if (qend) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;
                if (state_q == S_START && qtr_q == 2'd1) begin state_d = S_BITS; qtr_d = '0; end
                else if (state_q == S_BITS && qtr_q == 2'd3) begin
                    bit_d = bit_q + 5'd1;
                    sh_d  = sh_q << 1;
                    if (bit_q == 5'(FRAME_BITS - 1)) state_d = S_STOP;
                end
                else if (state_q == S_STOP && qtr_q == 2'd2) begin state_d = S_GAP; qtr_d = '0; end
                else if (state_q == S_GAP && qtr_q == 2'd3) begin state_d = adv_state; idx_d = adv_idx; end
            end
            S_DONE: if (bus.start) begin state_d = S_FETCH; idx_d = '0; end
            default: state_d = S_PWDN;
        endcase
    end
    always_comb begin
        sioc_d = state_d == S_START ? qtr_d == 2'd0 :
                 state_d == S_BITS  ? (qtr_d == 2'd1 || qtr_d == 2'd2) :
                 state_d == S_STOP  ? qtr_d != 2'd0 : 1'b1;
        siod_d = state_d == S_START ? 1'b0 :
                 state_d == S_BITS  ? sh_d[FRAME_BITS-1] :
                 state_d == S_STOP  ? qtr_d == 2'd2 : 1'b1;
    end
    always_ff @(posedge CLK_IN or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_PWDN;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            sioc_q  <= 1'b1;
            siod_q  <= 1'b1;
            pwdn_q  <= 1'b1;
            rst_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            sioc_q  <= sioc_d;
            siod_q  <= siod_d;
            pwdn_q  <= state_d == S_PWDN;
            rst_q   <= state_d != S_PWDN;
            busy_q  <= state_d != S_DONE;
            done_q  <= state_d == S_DONE;
        end
    end
    assign bus.CMOS_SIO_C = sioc_q;
    assign bus.CMOS_SIO_D = siod_q;
    assign bus.CMOS_PWDN  = pwdn_q;
    assign bus.CMOS_RESET = rst_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_idx    = idx_q;
endmodule
